// File: rtl/native_rd_sched_pkg.sv
// Shared types and constants for the native video read scheduler.
// Used by native_rd_sched and native_rd_addr_gen.
package native_rd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [31:0] MODE_LINE = "LINE";
  localparam logic [31:0] MODE_ONCE = "ONCE";
  localparam logic [15:0] SAT16     = 16'hFFFF;

endpackage

// File: rtl/native_rd_addr_gen.sv
// Line address walker: loads the frame base and stride, then steps by the stride.
// The accumulator means line addresses never need a multiply.
module native_rd_addr_gen
  import native_rd_sched_pkg::*;
#(
  parameter int AWIDTH = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] line_stride,
  output logic [AWIDTH-1:0] cur_addr
);

  logic [AWIDTH-1:0] sh_stride;

  // cur_addr doubles as the shadow base: it takes base_addr on load
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      sh_stride <= '0;
    end else if (load) begin
      cur_addr  <= base_addr;
      sh_stride <= line_stride;
    end else if (advance) begin
      cur_addr  <= cur_addr + sh_stride;
    end
  end

endmodule

// File: rtl/native_rd_sched.sv
// Frame-buffer read scheduler for the native video path (MODE "LINE" or "ONCE").
// Define NATIVE_RD_SCHED_UNDERRUN_EN to build the saturating underrun counter.
module native_rd_sched
  import native_rd_sched_pkg::*;
#(
  parameter logic [31:0] MODE   = MODE_LINE,
  parameter int          AWIDTH = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] line_stride,
  input  logic [15:0]       vactive,
  input  logic [15:0]       hactive,
  input  logic              falign,
  input  logic              lalign,
  input  logic              ealign,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [AWIDTH-1:0] req_addr,
  output logic [31:0]       req_len,
  input  logic              rd_done,
  output logic              busy,
  output logic [15:0]       line_idx,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       underrun_cnt
);

  localparam bit ONCE_M = (MODE == MODE_ONCE);

  state_t      state;
  state_t      nxt;
  logic        load;
  logic        adv;
  logic        geom_ok;
  logic        pend;
  logic        resync;
  logic [15:0] sh_vactive;
  logic [31:0] frame_len;

  assign geom_ok   = (vactive != 16'd0) && (hactive != 16'd0);
  assign frame_len = {16'd0, hactive} * {16'd0, vactive};

  native_rd_addr_gen #(
    .AWIDTH (AWIDTH)
  ) u_addr_gen (
    .clock       (clock),
    .rst_n       (rst_n),
    .load        (load),
    .advance     (adv),
    .base_addr   (base_addr),
    .line_stride (line_stride),
    .cur_addr    (req_addr)
  );

  // Next-state decode; load/adv must be combinational so the address lands with req_valid
  always_comb begin
    nxt  = state;
    load = 1'b0;
    adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && falign && geom_ok) begin
          load = 1'b1;
          nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_ready) nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_done) begin
          if (!enable) begin
            nxt = ST_IDLE;
          end else if (resync || falign) begin
            load = geom_ok;
            nxt  = geom_ok ? ST_REQ : ST_IDLE;
          end else if (ONCE_M) begin
            nxt = ST_DONE;
          end else begin
            adv = 1'b1;
            if (line_idx + 16'd1 == sh_vactive) nxt = ST_DONE;
            else if (pend || lalign)            nxt = ST_REQ;
            else                                nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          nxt = ST_IDLE;
        end else if (falign) begin
          load = geom_ok;
          nxt  = geom_ok ? ST_REQ : ST_IDLE;
        end else if (lalign) begin
          nxt = ST_REQ;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          nxt = ST_IDLE;
        end else if (falign) begin
          load = geom_ok;
          nxt  = geom_ok ? ST_REQ : ST_IDLE;
        end else if (ealign) begin
          nxt = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_valid  <= 1'b0;
      busy       <= 1'b0;
      req_len    <= '0;
      line_idx   <= '0;
      frame_cnt  <= '0;
      sh_vactive <= '0;
      pend       <= 1'b0;
      resync     <= 1'b0;
    end else begin
      state     <= nxt;
      req_valid <= (nxt == ST_REQ);
      busy      <= (nxt != ST_IDLE);

      if (load) begin
        line_idx   <= '0;
        sh_vactive <= vactive;
        req_len    <= ONCE_M ? frame_len : {16'd0, hactive};
      end else if (adv) begin
        line_idx   <= line_idx + 16'd1;
      end

      // Pending lalign and resync only live while a request is in flight
      if (load || (state == ST_WAIT && rd_done)) begin
        pend   <= 1'b0;
        resync <= 1'b0;
      end else if (state == ST_REQ || state == ST_WAIT) begin
        if (lalign) pend   <= 1'b1;
        if (falign) resync <= 1'b1;
      end

      if (state == ST_DONE && (ealign || falign)) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef NATIVE_RD_SCHED_UNDERRUN_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == SAT16) ? v : v + 16'd1;
  endfunction

  logic ur_hit;
  assign ur_hit = lalign && (state == ST_REQ || (state == ST_WAIT && !rd_done));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)      underrun_cnt <= '0;
    else if (ur_hit) underrun_cnt <= sat_inc16(underrun_cnt);
  end
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule
